// File: rtl/router_in_fifo.sv
// router_in_fifo: per-client input buffer in front of the router controller.
// Exposes empty/full/count from registered state only, returns the popped word
// on data_out one clock after the pop, and keeps sticky overflow/underflow flags.
module router_in_fifo #(
   parameter  int WIDTH  = 32,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [WIDTH-1:0]  data_in,
   output logic              full,
   input  logic              pop,
   output logic              empty,
   output logic [WIDTH-1:0]  data_out,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W:0]   count_q;
   logic [WIDTH-1:0]  data_out_q;
   logic              overflow_q;
   logic              underflow_q;

   logic              push_ok;
   logic              pop_ok;
   logic              push_drop;
   logic              pop_miss;
   logic [ADDR_W:0]   count_next;

   // Status flags come straight from the registered occupancy.
   assign full      = (count_q == FULL_COUNT);
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign data_out  = data_out_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Qualify strobes: a push into a full FIFO is only accepted alongside a pop.
   always_comb begin
      push_ok   = push && (!full || pop);
      pop_ok    = pop && !empty;
      push_drop = push && full && !pop;
      pop_miss  = pop && empty;
   end

   // Occupancy moves only when exactly one of push/pop is effective.
   always_comb begin
      count_next = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_next = count_q + 1'b1;
         2'b01:   count_next = count_q - 1'b1;
         default: count_next = count_q;
      endcase
   end

   // Storage array; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem[wptr] <= data_in;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (pop_ok) begin
            rptr <= rptr + 1'b1;
         end
         count_q <= count_next;
      end
   end

   // Registered read port: loaded on an effective pop, holds otherwise (no bypass).
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_q <= '0;
      end else if (pop_ok) begin
         data_out_q <= mem[rptr];
      end
   end

   // Sticky debug flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_drop) begin
            overflow_q <= 1'b1;
         end
         if (pop_miss) begin
            underflow_q <= 1'b1;
         end
      end
   end

endmodule
